mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port unified memory between instruction fetch (F stage) and
//   data access (M stage) of the 5-stage pipeline.
//   Sequences each transaction as request, wait-for-ready, then a one-cycle response.
//   Produces StallMemF/StallMemD-side stalls that are ORed into the hazard unit's stalls.
//   Data side has priority. A fairness bit keeps fetch from starving.
// PARAMETERS
//   AW       32   address width (byte address, passed through unmodified)
//   DW       32   data width
//   TIMEOUT  255  max cycles in a BUSY state without MemReady before abort; 8-bit counter
// PORTS
//   clk          in   1   clock, all state updates on rising edge
//   rst_n        in   1   synchronous reset, active low
//   InstReqF     in   1   fetch request; held until StallMemF falls
//   InstAddrF    in   AW  fetch address; stable while InstReqF
//   FlushF       in   1   branch redirect: discard any in-flight fetch result
//   DataReqM     in   1   data request; held until StallMemM falls
//   DataWeM      in   1   1 = store, 0 = load
//   DataAddrM    in   AW  data address
//   DataWDataM   in   DW  store data
//   InstRDataF   out  DW  fetched word, valid when InstValidF
//   InstValidF   out  1   one-cycle pulse: fetch complete
//   DataRDataM   out  DW  load data, valid when DataValidM
//   DataValidM   out  1   one-cycle pulse: data access complete (load or store)
//   StallMemF    out  1   stall F/D: fetch outstanding
//   StallMemM    out  1   stall M and all earlier stages: data access outstanding
//   MemErr       out  1   sticky: a transaction timed out
//   MemReq       out  1   memory request, registered
//   MemWe        out  1   memory write enable, registered
//   MemAddr      out  AW  memory address, registered
//   MemWData     out  DW  memory write data, registered
//   MemRData     in   DW  memory read data, sampled when MemReady
//   MemReady     in   1   memory completes the current request this cycle
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, MemReq/MemWe=0, MemAddr/MemWData=0,
//     Inst/DataRData=0, Valid pulses=0, MemErr=0, fair=0, Owner=DATA, Cancel=0, Cnt=0.
//   Reset overrides everything mid-transaction. A late MemReady after reset is ignored in IDLE.
//   States: IDLE, BUSY_D, BUSY_I, RESP.
//   IDLE grant rule:
//     - Data only: BUSY_D.
//     - Fetch only: BUSY_I.
//     - Both pending, fair=0: BUSY_D.
//     - Both pending, fair=1: BUSY_I.
//     - On grant, register MemReq=1 and MemAddr/MemWe/MemWData. For fetch, MemWe=0.
//   BUSY_x:
//     - MemReq and all Mem* outputs are held constant; Cnt increments.
//     - MemReady=1: capture MemRData into the owner's RData register, go to RESP, MemReq=0.
//     - Cnt==TIMEOUT and no MemReady: go to RESP, RData=0, MemErr<=1, MemReq=0.
//   RESP (one cycle):
//     - Owner's Valid pulses high, unless Owner=INST and Cancel=1.
//     - No new grant is made in this cycle, because the requester still presents its old request.
//     - Then go to IDLE; Cnt=0; Cancel=0.
//     - fair<=1 if Owner=DATA, fair<=0 if Owner=INST.
//   FlushF during BUSY_I or RESP(INST): set Cancel. Memory cannot abort, so the cycle still
//     completes and the result is dropped. FlushF in IDLE or BUSY_D has no effect.
//   Stalls (combinational):
//     - StallMemF = InstReqF & ~InstValidF.
//     - StallMemM = DataReqM & ~DataValidM.
//     - A cancelled fetch keeps StallMemF high until a fresh fetch completes.
//   Latency: request seen in IDLE at cycle N, MemReq at N+1, MemReady at N+1+w, Valid at N+2+w.
//     Minimum 3 cycles with zero-wait memory (w=0).
//   MemReady while in IDLE/RESP: ignored. Valid pulses never overlap. MemErr clears only on reset.
// TESTING
//   1 Fetch only: InstReqF=1, addr 0x0040, MemReady at 1st BUSY cycle, MemRData 0x2408_0005
//     -> MemReq on cycle 1, InstValidF on cycle 2 with 0x2408_0005, StallMemF low only on cycle 2.
//   2 Both requests at cycle 0, fair=0: load 0x1000 -> BUSY_D first. Then fetch is served next even
//     though DataReqM is re-raised immediately (fair=1). Check the order D,I,D.
//   3 Store DataWeM=1, addr 0x2004, wdata 0xDEAD_BEEF, MemReady after 4 waits -> MemWe=1,
//     MemWData stable for 5 cycles, DataValidM on cycle 6, DataRDataM ignored.
//   4 FlushF during BUSY_I with MemReady 2 cycles later -> no InstValidF. New fetch at 0x0080
//     issues only after RESP+IDLE and completes normally.
//   5 MemReady never asserted, TIMEOUT=255 -> RESP after 256 BUSY cycles, RData=0, Valid pulses,
//     MemErr=1 and stays 1 until rst_n=0.
//   6 rst_n=0 during BUSY_D -> next cycle all outputs at reset values. A stray MemReady in IDLE
//     produces no Valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between instruction fetch (F stage)
//   and data access (M stage). Each transaction is a registered request, a
//   wait for MemReady (bounded by TIMEOUT), then a one-cycle response.
//   Data has priority; a fairness bit hands the next contended grant to fetch
//   after every data access so fetch cannot starve.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   InstReqF/InstAddrF/FlushF  fetch request, address, branch redirect
//   DataReqM/DataWeM/DataAddrM/DataWDataM  data request, store flag, addr, wdata
//   InstRDataF/InstValidF      fetched word + one-cycle completion pulse
//   DataRDataM/DataValidM      load word + one-cycle completion pulse
//   StallMemF/StallMemM        stalls ORed into the hazard unit
//   MemErr                     sticky timeout flag
//   MemReq/MemWe/MemAddr/MemWData  registered memory request
//   MemRData/MemReady          memory response
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          InstReqF,
  input  logic [AW-1:0] InstAddrF,
  input  logic          FlushF,
  input  logic          DataReqM,
  input  logic          DataWeM,
  input  logic [AW-1:0] DataAddrM,
  input  logic [DW-1:0] DataWDataM,
  output logic [DW-1:0] InstRDataF,
  output logic          InstValidF,
  output logic [DW-1:0] DataRDataM,
  output logic          DataValidM,
  output logic          StallMemF,
  output logic          StallMemM,
  output logic          MemErr,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemReady
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_t;

  state_t        state, stateNext;
  logic          ownerInst;   // 0 = DATA owns the current transaction
  logic          fair;        // 1 = fetch wins the next contended grant
  logic          cancel;      // in-flight fetch result must be dropped
  logic [7:0]    cnt;
  logic          grantD, grantI, busy, timeout, done;
  logic [DW-1:0] respData;

  assign grantD   = DataReqM & (~InstReqF | ~fair);
  assign grantI   = InstReqF & ~grantD;
  assign busy     = (state == BUSY_D) || (state == BUSY_I);
  assign timeout  = busy & ~MemReady & (cnt == TIMEOUT[7:0]);
  assign done     = busy & (MemReady | timeout);
  // A timed-out access returns zero rather than whatever is on the bus.
  assign respData = MemReady ? MemRData : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (grantD)      stateNext = BUSY_D;
        else if (grantI) stateNext = BUSY_I;
      end
      BUSY_D, BUSY_I: if (done) stateNext = RESP;
      // Requesters still present the completed request here, so never grant.
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output logic. A redirect arriving in the response cycle itself also
  // suppresses the fetch pulse: that word belongs to the discarded path.
  always_comb begin
    InstValidF = (state == RESP) & ownerInst & ~cancel & ~FlushF;
    DataValidM = (state == RESP) & ~ownerInst;
    // A cancelled fetch never pulses, so F stays stalled until a fresh fetch lands.
    StallMemF  = InstReqF & ~InstValidF;
    StallMemM  = DataReqM & ~DataValidM;
  end

  // Request registers, response data and bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MemReq     <= 1'b0;
      MemWe      <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      InstRDataF <= '0;
      DataRDataM <= '0;
      MemErr     <= 1'b0;
      fair       <= 1'b0;
      ownerInst  <= 1'b0;
      cancel     <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt    <= '0;
          cancel <= 1'b0;
          if (grantD) begin
            MemReq    <= 1'b1;
            MemWe     <= DataWeM;
            MemAddr   <= DataAddrM;
            MemWData  <= DataWDataM;
            ownerInst <= 1'b0;
          end else if (grantI) begin
            MemReq    <= 1'b1;
            MemWe     <= 1'b0;
            MemAddr   <= InstAddrF;
            ownerInst <= 1'b1;
          end
        end
        BUSY_D, BUSY_I: begin
          // Memory cannot abort; a redirect only marks the result as stale.
          if (state == BUSY_I && FlushF) cancel <= 1'b1;
          if (done) begin
            MemReq <= 1'b0;
            if (state == BUSY_I) InstRDataF <= respData;
            else                 DataRDataM <= respData;
            if (!MemReady) MemErr <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          cnt    <= '0;
          cancel <= 1'b0;
          fair   <= ~ownerInst;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard queue holds expected
// responses in order; a negedge monitor pops one per Valid pulse.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InstReqF, FlushF, DataReqM, DataWeM, MemReady;
  logic [31:0] InstAddrF, DataAddrM, DataWDataM, MemRData;
  logic [31:0] InstRDataF, DataRDataM, MemAddr, MemWData;
  logic        InstValidF, DataValidM, StallMemF, StallMemM, MemErr, MemReq, MemWe;

  typedef struct packed {
    logic        inst;
    logic        chkData;
    logic [31:0] data;
  } resp_t;

  resp_t sbQ[$];
  int    passCnt = 0;
  int    totalCnt = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .InstReqF(InstReqF), .InstAddrF(InstAddrF), .FlushF(FlushF),
    .DataReqM(DataReqM), .DataWeM(DataWeM), .DataAddrM(DataAddrM), .DataWDataM(DataWDataM),
    .InstRDataF(InstRDataF), .InstValidF(InstValidF),
    .DataRDataM(DataRDataM), .DataValidM(DataValidM),
    .StallMemF(StallMemF), .StallMemM(StallMemM), .MemErr(MemErr),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemReady(MemReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Response monitor
  always @(negedge clk) begin
    resp_t e;
    if (rst_n === 1'b1 && (InstValidF || DataValidM)) begin
      chk("noOverlap", {31'd0, InstValidF & DataValidM}, 32'd0);
      if (sbQ.size() == 0) begin
        chk("unexpectedValid", {31'd0, InstValidF}, {31'd0, ~InstValidF});
      end else begin
        e = sbQ.pop_front();
        chk("respOwner", {31'd0, InstValidF}, {31'd0, e.inst});
        if (e.chkData) chk("respData", InstValidF ? InstRDataF : DataRDataM, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; InstReqF = 1'b0; InstAddrF = '0; FlushF = 1'b0;
    DataReqM = 1'b0; DataWeM = 1'b0; DataAddrM = '0; DataWDataM = '0;
    MemRData = '0; MemReady = 1'b0;
    repeat (3) cyc();
    smp();
    chk("rstMemReq", {31'd0, MemReq}, 32'd0);
    chk("rstMemAddr", MemAddr, 32'd0);
    chk("rstMemErr", {31'd0, MemErr}, 32'd0);
    chk("rstValid", {30'd0, InstValidF, DataValidM}, 32'd0);
    chk("rstRData", InstRDataF | DataRDataM, 32'd0);
    cyc(); rst_n = 1'b1;
    cyc();

    // 1: fetch only, zero-wait memory
    InstReqF = 1'b1; InstAddrF = 32'h40;
    sbQ.push_back('{inst: 1'b1, chkData: 1'b1, data: 32'h2408_0005});
    smp(); chk("t1StallC0", {31'd0, StallMemF}, 32'd1); chk("t1ReqC0", {31'd0, MemReq}, 32'd0);
    cyc(); MemReady = 1'b1; MemRData = 32'h2408_0005;
    smp(); chk("t1ReqC1", {31'd0, MemReq}, 32'd1); chk("t1Addr", MemAddr, 32'h40);
    chk("t1We", {31'd0, MemWe}, 32'd0); chk("t1StallC1", {31'd0, StallMemF}, 32'd1);
    cyc(); MemReady = 1'b0;
    smp(); chk("t1ValidC2", {31'd0, InstValidF}, 32'd1); chk("t1StallC2", {31'd0, StallMemF}, 32'd0);
    cyc(); InstReqF = 1'b0;
    smp(); chk("t1ValidC3", {31'd0, InstValidF}, 32'd0);
    cyc();

    // 2: contention, order D, I, D
    DataReqM = 1'b1; DataWeM = 1'b0; DataAddrM = 32'h1000;
    InstReqF = 1'b1; InstAddrF = 32'h44;
    sbQ.push_back('{inst: 1'b0, chkData: 1'b1, data: 32'h1111_1111});
    sbQ.push_back('{inst: 1'b1, chkData: 1'b1, data: 32'h2222_2222});
    sbQ.push_back('{inst: 1'b0, chkData: 1'b1, data: 32'h3333_3333});
    cyc(); MemReady = 1'b1; MemRData = 32'h1111_1111;
    smp(); chk("t2AddrD1", MemAddr, 32'h1000);
    cyc(); MemReady = 1'b0;
    smp(); chk("t2StallM", {31'd0, StallMemM}, 32'd0); chk("t2StallF", {31'd0, StallMemF}, 32'd1);
    cyc(); DataAddrM = 32'h1004;
    cyc(); MemReady = 1'b1; MemRData = 32'h2222_2222;
    smp(); chk("t2AddrI", MemAddr, 32'h44); chk("t2WeI", {31'd0, MemWe}, 32'd0);
    cyc(); MemReady = 1'b0;
    cyc(); InstReqF = 1'b0;
    cyc(); MemReady = 1'b1; MemRData = 32'h3333_3333;
    smp(); chk("t2AddrD2", MemAddr, 32'h1004);
    cyc(); MemReady = 1'b0;
    cyc(); DataReqM = 1'b0;
    cyc();

    // 3: store with 4 wait cycles
    DataReqM = 1'b1; DataWeM = 1'b1; DataAddrM = 32'h2004; DataWDataM = 32'hDEAD_BEEF;
    sbQ.push_back('{inst: 1'b0, chkData: 1'b0, data: 32'h0});
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 5) begin MemReady = 1'b1; MemRData = 32'h0000_55AA; end
      smp();
      chk("t3Req", {31'd0, MemReq}, 32'd1);
      chk("t3We", {31'd0, MemWe}, 32'd1);
      chk("t3WData", MemWData, 32'hDEAD_BEEF);
      chk("t3Addr", MemAddr, 32'h2004);
    end
    cyc(); MemReady = 1'b0;
    smp(); chk("t3Valid", {31'd0, DataValidM}, 32'd1);
    cyc(); DataReqM = 1'b0; DataWeM = 1'b0;
    cyc();

    // 4: fetch flushed in flight, then redirected fetch
    InstReqF = 1'b1; InstAddrF = 32'h40;
    sbQ.push_back('{inst: 1'b1, chkData: 1'b1, data: 32'h0A0A_0A0A});
    cyc(); FlushF = 1'b1; InstAddrF = 32'h80;
    cyc(); FlushF = 1'b0;
    cyc(); MemReady = 1'b1; MemRData = 32'h0BAD_0BAD;
    smp(); chk("t4StallBusy", {31'd0, StallMemF}, 32'd1);
    cyc(); MemReady = 1'b0;
    smp(); chk("t4NoValid", {31'd0, InstValidF}, 32'd0); chk("t4StallResp", {31'd0, StallMemF}, 32'd1);
    cyc();
    smp(); chk("t4IdleReq", {31'd0, MemReq}, 32'd0);
    cyc(); MemReady = 1'b1; MemRData = 32'h0A0A_0A0A;
    smp(); chk("t4Addr", MemAddr, 32'h80);
    cyc(); MemReady = 1'b0;
    smp(); chk("t4Valid", {31'd0, InstValidF}, 32'd1);
    cyc(); InstReqF = 1'b0;
    cyc();

    // 5: timeout after 256 busy cycles
    DataReqM = 1'b1; DataWeM = 1'b0; DataAddrM = 32'h3000;
    sbQ.push_back('{inst: 1'b0, chkData: 1'b1, data: 32'h0});
    cyc();
    repeat (255) cyc();
    smp(); chk("t5ReqLast", {31'd0, MemReq}, 32'd1); chk("t5ErrBefore", {31'd0, MemErr}, 32'd0);
    cyc();
    smp(); chk("t5Valid", {31'd0, DataValidM}, 32'd1); chk("t5Err", {31'd0, MemErr}, 32'd1);
    cyc(); DataReqM = 1'b0;
    repeat (3) cyc();
    smp(); chk("t5ErrSticky", {31'd0, MemErr}, 32'd1);
    cyc();

    // 6: reset mid-transaction, stray MemReady afterwards
    DataReqM = 1'b1; DataAddrM = 32'h4000;
    cyc();
    smp(); chk("t6Busy", {31'd0, MemReq}, 32'd1);
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; DataReqM = 1'b0; MemReady = 1'b1; MemRData = 32'h7777_7777;
    smp(); chk("t6RstReq", {31'd0, MemReq}, 32'd0); chk("t6RstAddr", MemAddr, 32'h0);
    chk("t6RstErr", {31'd0, MemErr}, 32'd0); chk("t6RstRData", InstRDataF | DataRDataM, 32'h0);
    cyc();
    smp(); chk("t6NoValid", {30'd0, InstValidF, DataValidM}, 32'd0);
    cyc(); MemReady = 1'b0;
    smp(); chk("t6IdleReq", {31'd0, MemReq}, 32'd0);
    cyc();

    chk("sbEmpty", sbQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
